// File: rtl/mac_sa_inserter_pkg.sv
// mac_sa_inserter_pkg: shared Ethernet header offsets and MAC address type
package mac_sa_inserter_pkg;
  localparam int SA_MAC_OFFSET = 6;
  localparam int SA_MAC_SIZE = 48;
  localparam int DA_MAC_OFFSET = 0;
  localparam int ET_OFFSET = 12;
  localparam int LAST_BYTE = 13;
  typedef logic [47:0] mac_addr_t;
  function automatic int eff_w(input int w);
    return w < 1 ? 1 : w;
  endfunction
endpackage

// File: rtl/mac_sa_inserter_if.sv
// mac_sa_inserter_if: AXI-Stream bundle with master/slave views
interface mac_sa_inserter_if #(
  parameter int DATA_W = 64,
  parameter int ID_W = 4,
  parameter int DEST_W = 4
);
  logic [DATA_W-1:0] tdata;
  logic [DATA_W/8-1:0] tkeep;
  logic [ID_W-1:0] tid;
  logic [DEST_W-1:0] tdest;
  logic tlast;
  logic tvalid;
  logic tready;
  modport master(output tdata, tkeep, tid, tdest, tlast, tvalid, input tready);
  modport slave(input tdata, tkeep, tid, tdest, tlast, tvalid, output tready);
endinterface

// File: rtl/mac_sa_inserter_axis_skid_slice.sv
// axis_skid_slice: two-entry registered slice; ready comes from a flop, never from dst_ready
module axis_skid_slice #(
  parameter int WIDTH = 8
) (
  input  logic             aclk,
  input  logic             aresetn,
  input  logic [WIDTH-1:0] src_data,
  input  logic             src_valid,
  output logic             src_ready,
  output logic [WIDTH-1:0] dst_data,
  output logic             dst_valid,
  input  logic             dst_ready
);
  logic [WIDTH-1:0] skid_data;
  logic skid_valid, skid_nxt, load, fire;
  assign fire = src_valid && src_ready;
  assign load = !dst_valid || dst_ready;
  assign skid_nxt = skid_valid ? !load : fire && !load;
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      dst_valid <= 1'b0;
      skid_valid <= 1'b0;
      src_ready <= 1'b0;
    end else begin
      src_ready <= !skid_nxt;
      skid_valid <= skid_nxt;
      if (load) dst_valid <= skid_valid || fire;
    end
    if (load) dst_data <= skid_valid ? skid_data : src_data;
    if (fire && !load) skid_data <= src_data;
  end
endmodule

// File: rtl/mac_sa_inserter.sv
// mac_sa_inserter: stamps the per-tenant station MAC into the Ethernet source address
module mac_sa_inserter
  import mac_sa_inserter_pkg::*;
#(
  parameter int AXIS_BUS_WIDTH = 64,
  parameter int AXIS_ID_WIDTH = 4,
  parameter int AXIS_DEST_WIDTH = 4,
  parameter int MAX_PACKET_LENGTH = 1522,
  localparam int IW = eff_w(AXIS_ID_WIDTH),
  localparam int NUM_AXIS_ID = 2 ** IW
) (
  input  logic                   aclk,
  input  logic                   aresetn,
  mac_sa_inserter_if.slave       axis_in,
  mac_sa_inserter_if.master      axis_out,
  input  mac_addr_t              mac_addresses [NUM_AXIS_ID],
  input  logic [NUM_AXIS_ID-1:0] mac_sa_overwrite,
  output logic                   runt_pulse,
  output logic [31:0]            rewrite_count
);
  localparam int NBB = AXIS_BUS_WIDTH / 8;
  localparam int DW = eff_w(AXIS_DEST_WIDTH);
  localparam int PW = $clog2(MAX_PACKET_LENGTH + 1);
  localparam int PLW = AXIS_BUS_WIDTH + NBB + IW + DW + 1;
  logic [PW-1:0] pos;
  logic [IW-1:0] id_q, id;
  logic [AXIS_BUS_WIDTH-1:0] tdata;
  logic [PLW-1:0] payload, out_payload;
  logic fire, ow, runt;
  assign fire = axis_in.tvalid && axis_in.tready;
  assign id = pos == '0 ? axis_in.tid : id_q;
  assign ow = mac_sa_overwrite[id];
  assign runt = int'(pos) + NBB <= LAST_BYTE;
  // each lane compares its absolute byte index against the SA window
  always_comb begin
    tdata = axis_in.tdata;
    for (int b = 0; b < NBB; b++)
      if (ow && int'(pos) + b >= SA_MAC_OFFSET && int'(pos) + b < SA_MAC_OFFSET + SA_MAC_SIZE / 8)
        tdata[8*b +: 8] = mac_addresses[id][8*(int'(pos) + b - SA_MAC_OFFSET) +: 8];
  end
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      pos <= '0;
      id_q <= '0;
      runt_pulse <= 1'b0;
      rewrite_count <= '0;
    end else begin
      runt_pulse <= fire && axis_in.tlast && runt;
      if (fire) begin
        id_q <= id;
        pos <= axis_in.tlast ? '0 : pos + PW'(NBB);
      end
      if (fire && axis_in.tlast && ow && !runt && rewrite_count != '1)
        rewrite_count <= rewrite_count + 32'd1;
    end
  end
  assign payload = {tdata, axis_in.tkeep, axis_in.tid, axis_in.tdest, axis_in.tlast};
  axis_skid_slice #(.WIDTH(PLW)) u_skid (
    .aclk(aclk),
    .aresetn(aresetn),
    .src_data(payload),
    .src_valid(axis_in.tvalid),
    .src_ready(axis_in.tready),
    .dst_data(out_payload),
    .dst_valid(axis_out.tvalid),
    .dst_ready(axis_out.tready)
  );
  assign {axis_out.tdata, axis_out.tkeep, axis_out.tid, axis_out.tdest, axis_out.tlast} = out_payload;
endmodule

// File: tb/tb_mac_sa_inserter.sv
// tb_mac_sa_inserter: random packets against a byte-array model of SA rewriting
module tb_mac_sa_inserter;
  import mac_sa_inserter_pkg::*;
  localparam int NB = 8;
  typedef struct {
    logic [80:0] p;
    int acc;
  } exp_t;
  logic aclk = 1'b0;
  logic aresetn = 1'b0;
  always #5 aclk = ~aclk;
  mac_sa_inserter_if #(.DATA_W(64), .ID_W(4), .DEST_W(4)) in_if ();
  mac_sa_inserter_if #(.DATA_W(64), .ID_W(4), .DEST_W(4)) out_if ();
  mac_addr_t macs [16];
  logic [15:0] ovw;
  logic runt_pulse;
  logic [31:0] rewrite_count;
  mac_sa_inserter dut (
    .aclk(aclk),
    .aresetn(aresetn),
    .axis_in(in_if),
    .axis_out(out_if),
    .mac_addresses(macs),
    .mac_sa_overwrite(ovw),
    .runt_pulse(runt_pulse),
    .rewrite_count(rewrite_count)
  );
  exp_t q[$];
  int total = 0, bad = 0, cyc = 0, ready_mode = 1;
  logic lat_chk = 1'b0, stalled = 1'b0;
  logic [80:0] held;
  logic [31:0] n_rw = '0;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [80:0] pl_out();
    return {out_if.tdata, out_if.tkeep, out_if.tid, out_if.tdest, out_if.tlast};
  endfunction

  always @(posedge aclk) cyc <= cyc + 1;
  always @(posedge aclk) begin
    #1;
    out_if.tready = ready_mode == 2 ? 1'($urandom % 2) : ready_mode == 1;
  end

  always @(negedge aclk) begin
    if (!aresetn) stalled <= 1'b0;
    else begin
      if (stalled) begin
        chk("hold_valid", out_if.tvalid, 1);
        chk("hold_data", pl_out(), held);
      end
      if (out_if.tvalid && out_if.tready) begin
        if (q.size() == 0) chk("extra_beat", out_if.tvalid, 0);
        else begin
          chk("beat", pl_out(), q[0].p);
          if (lat_chk) chk("latency", cyc, q[0].acc);
          q.delete(0);
        end
      end
      stalled <= out_if.tvalid && !out_if.tready;
      held <= pl_out();
    end
  end

  task automatic send_pkt(input int n, input int id, input int nsend, input logic gaps);
    logic [7:0] ib[$], ob[$];
    logic [63:0] d, od;
    logic [7:0] k;
    logic [3:0] t, ds;
    logic l;
    int w;
    exp_t e;
    for (int i = 0; i < n * NB; i++) ib.push_back(8'($urandom));
    ob = ib;
    if (ovw[id])
      for (int i = SA_MAC_OFFSET; i < SA_MAC_OFFSET + 6 && i < n * NB; i++)
        ob[i] = macs[id][8*(i-SA_MAC_OFFSET) +: 8];
    for (int j = 0; j < nsend; j++) begin
      for (int b = 0; b < NB; b++) begin
        d[8*b +: 8] = ib[j*NB+b];
        od[8*b +: 8] = ob[j*NB+b];
      end
      l = j == n - 1;
      k = l ? 8'($urandom_range(1, 255)) : 8'hff;
      t = j == 0 ? 4'(id) : 4'($urandom);
      ds = 4'($urandom);
      if (gaps && $urandom % 4 == 0) begin
        in_if.tvalid = 1'b0;
        @(negedge aclk);
      end
      in_if.tdata = d;
      in_if.tkeep = k;
      in_if.tid = t;
      in_if.tdest = ds;
      in_if.tlast = l;
      in_if.tvalid = 1'b1;
      if (lat_chk) chk("throughput", in_if.tready, 1);
      w = 0;
      while (!in_if.tready) begin
        @(negedge aclk);
        w++;
        if (w > 2000) begin
          $display("FAIL accept_timeout: no tready after %0d cycles", w);
          $fatal(1);
        end
      end
      e.p = {od, k, t, ds, l};
      e.acc = cyc + 1;
      q.push_back(e);
      @(posedge aclk);
      @(negedge aclk);
      chk("runt", runt_pulse, l && n * NB <= LAST_BYTE);
      if (l) begin
        if (ovw[id] && n * NB > LAST_BYTE && n_rw != '1) n_rw++;
        chk("rewrite_count", rewrite_count, n_rw);
      end
    end
    in_if.tvalid = 1'b0;
  endtask

  task automatic drain();
    int w = 0;
    ready_mode = 1;
    while (q.size() != 0 && w < 200) begin
      @(negedge aclk);
      w++;
    end
    chk("drain", q.size(), 0);
  endtask

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n;
    in_if.tvalid = 1'b0;
    in_if.tdata = '0;
    in_if.tkeep = '0;
    in_if.tid = '0;
    in_if.tdest = '0;
    in_if.tlast = 1'b0;
    ovw = '0;
    for (int i = 0; i < 16; i++) macs[i] = {16'($urandom), $urandom};
    repeat (3) @(negedge aclk);
    chk("rst_out_valid", out_if.tvalid, 0);
    chk("rst_in_ready", in_if.tready, 0);
    chk("rst_runt", runt_pulse, 0);
    chk("rst_count", rewrite_count, 0);
    @(posedge aclk);
    #2 aresetn = 1'b1;
    @(posedge aclk);
    @(negedge aclk);
    chk("ready_after_rst", in_if.tready, 1);
    lat_chk = 1'b1;
    macs[2] = 48'h0605_0403_0201;
    ovw[2] = 1'b1;
    send_pkt(3, 2, 3, 1'b0);
    ovw[2] = 1'b0;
    send_pkt(3, 2, 3, 1'b0);
    ovw[1] = 1'b1;
    ovw[3] = 1'b1;
    send_pkt(3, 1, 3, 1'b0);
    send_pkt(3, 3, 3, 1'b0);
    ovw[2] = 1'b1;
    send_pkt(1, 2, 1, 1'b0);
    @(negedge aclk);
    chk("runt_one_cycle", runt_pulse, 0);
    drain();
    lat_chk = 1'b0;
    ready_mode = 2;
    repeat (100) begin
      ovw = 16'($urandom);
      n = $urandom_range(1, 5);
      send_pkt(n, $urandom_range(0, 15), n, 1'b1);
    end
    drain();
    ready_mode = 0;
    repeat (2) @(negedge aclk);
    ovw[5] = 1'b1;
    send_pkt(3, 5, 1, 1'b0);
    @(negedge aclk);
    chk("stuck_valid", out_if.tvalid, 1);
    @(posedge aclk);
    #2 aresetn = 1'b0;
    q.delete();
    n_rw = '0;
    ready_mode = 1;
    @(posedge aclk);
    #2 aresetn = 1'b1;
    @(negedge aclk);
    chk("midrst_out_valid", out_if.tvalid, 0);
    chk("midrst_in_ready", in_if.tready, 0);
    chk("midrst_count", rewrite_count, 0);
    send_pkt(3, 5, 3, 1'b0);
    drain();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/mac_sa_inserter.md
MAC_SA_INSERTER -- requirements
Module: mac_sa_inserter

Interface
REQ-001 Parameter AXIS_BUS_WIDTH, 64, stream data width in bits; SHALL be a multiple of 16 and at least 16.
REQ-002 Parameter AXIS_ID_WIDTH, 4, tid width; NUM_AXIS_ID = 2**AXIS_ID_WIDTH; effective width is at least 1.
REQ-003 Parameter AXIS_DEST_WIDTH, 4, tdest width; effective width is at least 1.
REQ-004 Parameter MAX_PACKET_LENGTH, 1522, maximum bytes per packet; sets the position counter width to clog2(MAX+1).
REQ-005 aclk  in  1  clock; all logic on the rising edge.
REQ-006 aresetn  in  1  reset, synchronous, active-low.
REQ-007 axis_in_tdata/tid/tdest/tkeep/tlast/tvalid  in; axis_in_tready  out: egress stream from tenant, ID = tid.
REQ-008 axis_out_tdata/tid/tdest/tkeep/tlast/tvalid  out; axis_out_tready  in: stream toward the MAC.
REQ-009 mac_addresses  in  [NUM_AXIS_ID] x 48  per-ID station MAC; MAC byte i = bits [8i+:8].
REQ-010 mac_sa_overwrite  in  [NUM_AXIS_ID] x 1  per-ID enable for source-address rewrite.
REQ-011 runt_pulse  out  1  one-cycle flag: a packet ended before byte 13.
REQ-012 rewrite_count  out  32  saturating count of packets whose SA was rewritten.

Function
REQ-013 Byte k of a packet SHALL be carried on tdata bits [8(k mod NUM_BUS_BYTES)+:8] of beat floor(k/NUM_BUS_BYTES).
REQ-014 A byte position counter SHALL advance by NUM_BUS_BYTES on each accepted input beat and SHALL clear to 0 on an accepted tlast beat.
REQ-015 The ID SHALL be latched from tid on the first beat of a packet (position 0); the latched value SHALL govern the entire packet.
REQ-016 When mac_sa_overwrite[ID]=1, packet bytes 6..11 SHALL be replaced by mac_addresses[ID] bytes 0..5, in whichever beats carry them; all other bytes pass unchanged.
REQ-017 When mac_sa_overwrite[ID]=0, the beat SHALL pass bit-exact.
REQ-018 Replacement SHALL be independent of tkeep; tkeep, tid, tdest and tlast SHALL pass unchanged.
REQ-019 Lane selection SHALL be constant where the SA lane offsets are bus-aligned; otherwise a mux is used.
REQ-020 The output SHALL be registered through a two-entry skid buffer with a latency of 1 cycle from an accepted input beat to axis_out_tvalid.
REQ-021 axis_in_tready SHALL equal "skid entry empty" and SHALL NOT depend combinationally on axis_out_tready.
REQ-022 Full throughput: one beat per cycle SHALL be sustained while axis_out_tready=1.
REQ-023 The skid buffer SHALL hold axis_out_* stable while tvalid=1 and tready=0.
REQ-024 runt_pulse SHALL assert for one cycle on an accepted tlast beat whose position + NUM_BUS_BYTES <= 13; the packet SHALL still be forwarded.
REQ-025 rewrite_count SHALL increment on an accepted tlast beat of a packet with overwrite enabled that is not a runt, and SHALL saturate at 0xFFFFFFFF.
REQ-026 Changes to mac_addresses or mac_sa_overwrite in mid-packet SHALL take effect on the next beat; the ID stays latched.
REQ-027 Simultaneous input accept and output drain SHALL neither lose nor duplicate a beat.

Reset
REQ-028 While aresetn=0, the following SHALL apply:
- axis_out_tvalid=0 and axis_in_tready=0.
- Skid buffer empty; position counter 0; runt_pulse=0; rewrite_count=0.
REQ-029 In the first cycle after reset, axis_in_tready SHALL be 1.
REQ-030 Reset in mid-packet SHALL discard buffered beats; the next accepted beat SHALL be treated as position 0.

Structure
REQ-031 A shared package SHALL hold:
- SA_MAC_OFFSET=6, SA_MAC_SIZE=48, DA_MAC_OFFSET=0, ET_OFFSET=12, LAST_BYTE=13.
- The mac_addr_t 48-bit typedef.
REQ-032 The skid buffer SHALL be one sub-module, axis_skid_slice, parameterized by payload width.

Verification
REQ-033 64-bit bus, ID 2, overwrite=1, mac_addresses[2]=0x0605_0403_0201, 3-beat packet -> output:
- beat0 bytes 6,7 = 01,02;
- beat1 bytes 0..3 = 03..06;
- everything else unchanged; rewrite_count=1.
REQ-034 Same packet with overwrite[2]=0 -> output bit-exact to input; rewrite_count unchanged.
REQ-035 Back-to-back packets with tid 1 then 3 (different MACs), tready held at 1 -> each packet is stamped with its own MAC; 1 beat/cycle; latency 1.
REQ-036 Random axis_out_tready toggling at 50% over 100 packets -> no beat lost, duplicated or reordered; outputs stable while stalled.
REQ-037 Single-beat 8-byte packet with tlast -> runt_pulse=1 for one cycle; bytes 6,7 rewritten; rewrite_count not incremented.
REQ-038 aresetn=0 for one cycle mid-packet, then a new packet -> first new beat treated as position 0 and rewritten correctly; no stale beat emitted.
